// File: rtl/pipelined_barrel_shifter.sv
`default_nettype none
// ============================================================================
// Module     : pipelined_barrel_shifter
// Description: WIDTH-bit ROR/ROL/SRL/SRA shifter, one register per log2 stage,
//              valid/ready handshake with backpressure on both sides.
// Revision   : 1.0  initial release
// ============================================================================
module pipelined_barrel_shifter #(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic [$clog2(WIDTH)-1:0]   in_amt,
    input  logic [1:0]                 in_mode,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_zero
);

    localparam int NSTG = $clog2(WIDTH);

    localparam logic [1:0] c_mode_ror = 2'b00;
    localparam logic [1:0] c_mode_rol = 2'b01;
    localparam logic [1:0] c_mode_srl = 2'b10;
    localparam logic [1:0] c_mode_sra = 2'b11;

    if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
        $error("pipelined_barrel_shifter: WIDTH must be a power of 2 and >= 2");
    end

    logic [NSTG-1:0]  r_valid;
    logic [NSTG-1:0]  r_sign;
    logic [WIDTH-1:0] r_data [NSTG];
    logic [NSTG-1:0]  r_amt  [NSTG];
    logic [1:0]       r_mode [NSTG];

    logic [NSTG-1:0]  w_load;
    logic [NSTG-1:0]  w_src_valid;
    logic [NSTG-1:0]  w_src_sign;
    logic [WIDTH-1:0] w_src_data  [NSTG];
    logic [WIDTH-1:0] w_next_data [NSTG];
    logic [NSTG-1:0]  w_src_amt   [NSTG];
    logic [1:0]       w_src_mode  [NSTG];

    // A stage may load when empty or when its occupant moves on this cycle,
    // so bubbles collapse even while the output is stalled.
    always_comb begin
        w_load = '0;
        w_load[NSTG-1] = ~r_valid[NSTG-1] | out_ready;
        for (int k = NSTG - 2; k >= 0; k--) begin
            w_load[k] = ~r_valid[k] | w_load[k+1];
        end
    end

    for (genvar k = 0; k < NSTG; k++) begin : g_stage
        localparam int c_sh = 1 << k;
        logic [WIDTH-1:0] w_shifted;

        if (k == 0) begin : g_first
            assign w_src_valid[k] = in_valid;
            assign w_src_sign[k]  = in_data[WIDTH-1];
            assign w_src_data[k]  = in_data;
            assign w_src_amt[k]   = in_amt;
            assign w_src_mode[k]  = in_mode;
        end else begin : g_chain
            assign w_src_valid[k] = r_valid[k-1];
            assign w_src_sign[k]  = r_sign[k-1];
            assign w_src_data[k]  = r_data[k-1];
            assign w_src_amt[k]   = r_amt[k-1];
            assign w_src_mode[k]  = r_mode[k-1];
        end

        always_comb begin
            w_shifted = w_src_data[k];
            case (w_src_mode[k])
                c_mode_ror: w_shifted = {w_src_data[k][c_sh-1:0], w_src_data[k][WIDTH-1:c_sh]};
                c_mode_rol: w_shifted = {w_src_data[k][WIDTH-c_sh-1:0], w_src_data[k][WIDTH-1:WIDTH-c_sh]};
                c_mode_srl: w_shifted = {{c_sh{1'b0}}, w_src_data[k][WIDTH-1:c_sh]};
                c_mode_sra: w_shifted = {{c_sh{w_src_sign[k]}}, w_src_data[k][WIDTH-1:c_sh]};
            endcase
        end

        assign w_next_data[k] = w_src_amt[k][k] ? w_shifted : w_src_data[k];
    end

    // Payload only updates on a valid load, keeping out_data quiet across bubbles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
            r_sign  <= '0;
            for (int k = 0; k < NSTG; k++) begin
                r_data[k] <= '0;
                r_amt[k]  <= '0;
                r_mode[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NSTG; k++) begin
                if (w_load[k]) begin
                    r_valid[k] <= w_src_valid[k];
                    if (w_src_valid[k]) begin
                        r_data[k] <= w_next_data[k];
                        r_amt[k]  <= w_src_amt[k];
                        r_mode[k] <= w_src_mode[k];
                        r_sign[k] <= w_src_sign[k];
                    end
                end
            end
        end
    end

    assign in_ready  = w_load[0];
    assign out_valid = r_valid[NSTG-1];
    assign out_data  = r_data[NSTG-1];
    assign out_zero  = ~|r_data[NSTG-1];

endmodule
`default_nettype wire
